// File: rtl/sram_bus_bridge_if.sv
// Core-side request/response channel between a CPU pipeline and the SRAM bridge.
// The core drives requests (master); the bridge answers with data and stall (slave).
interface sram_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  bus_en;
  logic [DATA_W/8-1:0]   bus_wen;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_streq;

  modport master (
    output bus_en, bus_wen, bus_addr, bus_wdata,
    input  bus_rdata, bus_streq
  );

  modport slave (
    input  bus_en, bus_wen, bus_addr, bus_wdata,
    output bus_rdata, bus_streq
  );
endinterface

// File: rtl/sram_bus_bridge.sv
// Adapter from a core bus channel to a synchronous SRAM with configurable read
// latency, optional write stall and a read-result hold register.
module sram_bus_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int WR_STALL = 0
) (
  input  logic                clk,
  input  logic                resetn,
  sram_bus_bridge_if.slave    bus,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_INIT_I = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
  localparam logic [1:0] CNT_INIT = 2'(CNT_INIT_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam state_t ST_RD_NEXT = (RD_LAT > 1) ? ST_WAIT : ST_DONE;

  state_t            state_r;
  logic [1:0]        cnt_r;
  logic              hold_valid_r;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [DATA_W-1:0] hold_data_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [DATA_W-1:0] req_wdata_r;
  logic              req_wr_r;

  logic rd_s;
  logic wr_s;
  logic hit_s;

  assign rd_s  = bus.bus_en && (bus.bus_wen == {BE_W{1'b0}});
  assign wr_s  = bus.bus_en && (bus.bus_wen != {BE_W{1'b0}});
  assign hit_s = hold_valid_r && (bus.bus_addr == hold_addr_r);

  // Bus and SRAM outputs; all strobes are forced low while reset is asserted.
  always_comb begin
    sram_en       = 1'b0;
    sram_wen      = {BE_W{1'b0}};
    sram_addr     = req_addr_r;
    sram_wdata    = req_wdata_r;
    bus.bus_streq = 1'b0;
    bus.bus_rdata = hold_data_r;
    if (!resetn) begin
      bus.bus_rdata = {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          sram_addr  = bus.bus_addr;
          sram_wdata = bus.bus_wdata;
          if (wr_s) begin
            sram_en       = 1'b1;
            sram_wen      = bus.bus_wen;
            bus.bus_streq = (WR_STALL != 0);
          end else if (rd_s && !hit_s) begin
            sram_en       = 1'b1;
            bus.bus_streq = 1'b1;
          end else begin
            sram_en       = 1'b0;
            bus.bus_streq = 1'b0;
          end
        end
        ST_WAIT: bus.bus_streq = 1'b1;
        ST_DONE: begin
          if (!req_wr_r) begin
            bus.bus_rdata = sram_rdata;
          end else begin
            bus.bus_rdata = hold_data_r;
          end
        end
        default: bus.bus_streq = 1'b0;
      endcase
    end
  end

  // Request tracking, latency countdown and hold-register maintenance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 2'd0;
      hold_valid_r <= 1'b0;
      hold_addr_r  <= {ADDR_W{1'b0}};
      hold_data_r  <= {DATA_W{1'b0}};
      req_addr_r   <= {ADDR_W{1'b0}};
      req_wdata_r  <= {DATA_W{1'b0}};
      req_wr_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wr_s) begin
            hold_valid_r <= 1'b0;
            req_addr_r   <= bus.bus_addr;
            req_wdata_r  <= bus.bus_wdata;
            req_wr_r     <= 1'b1;
            if (WR_STALL != 0) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (rd_s && !hit_s) begin
            hold_valid_r <= 1'b0;
            req_addr_r   <= bus.bus_addr;
            req_wr_r     <= 1'b0;
            cnt_r        <= CNT_INIT;
            state_r      <= ST_RD_NEXT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 2'd0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_DONE: begin
          // A flushed read still fills the hold register so the data is not lost.
          if (!req_wr_r) begin
            hold_data_r  <= sram_rdata;
            hold_addr_r  <= req_addr_r;
            hold_valid_r <= 1'b1;
          end else begin
            hold_valid_r <= hold_valid_r;
          end
          state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule
